// File: rtl/islemci_cok_cevrim.sv
// islemci_cok_cevrim: multi-cycle custom-ISA core with an iterative shift-add multiplier.
// Instructions arrive over a valid/ready handshake; undefined encodings retire as flagged no-ops.
module islemci_cok_cevrim #(
  parameter int XLEN      = 32,
  parameter int CARP_ADIM = 1,
  parameter int BAYT_TERS = 1
) (
  input  logic                saat,
  input  logic                reset,
  input  logic [31:0]         buyruk,
  input  logic                buyruk_gecerli,
  output logic                buyruk_hazir,
  output logic [31:0]         program_sayaci,
  output logic [32*XLEN-1:0]  yazmaclar,
  output logic                emekli,
  output logic                gecersiz_buyruk
);
  localparam int M  = XLEN / CARP_ADIM;
  localparam int SW = $clog2(M + 1);

  localparam logic [2:0] GETIR = 3'd0;
  localparam logic [2:0] COZ   = 3'd1;
  localparam logic [2:0] CARP1 = 3'd2;
  localparam logic [2:0] CARP2 = 3'd3;
  localparam logic [2:0] YAZ   = 3'd4;

  logic [2:0]      durum_reg, durum_next;
  logic [31:0]     buyruk_reg;
  logic [31:0]     pc_reg, pc_next;
  logic [XLEN-1:0] yazmac_reg [32];
  logic [XLEN-1:0] op1_reg, op2_reg;
  logic [XLEN-1:0] carpilan_reg, carpan_reg, birikim_reg, urun1_reg, sonuc_reg;
  logic [SW-1:0]   sayac_reg;
  logic            emekli_reg, emekli_next;
  logic            gecersiz_reg, gecersiz_next;

  logic [31:0] giris_sozcuk;
  generate
    if (BAYT_TERS != 0) begin : g_ters
      assign giris_sozcuk = {buyruk[7:0], buyruk[15:8], buyruk[23:16], buyruk[31:24]};
    end else begin : g_duz
      assign giris_sozcuk = buyruk;
    end
  endgenerate

  // The latched word stays put until retire, so decode is valid in every state.
  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign op  = buyruk_reg[6:0];
  assign rd  = buyruk_reg[11:7];
  assign f3  = buyruk_reg[14:12];
  assign rs1 = buyruk_reg[19:15];
  assign rs2 = buyruk_reg[24:20];
  assign f7  = buyruk_reg[31:25];

  logic op_ozel, op_dal;
  logic is_kareal, is_carp, is_sifrele, is_tasi, is_bitsay, is_dallan, is_atla;
  logic is_carpma, is_gecersiz;
  assign op_ozel     = (op == 7'b1110111);
  assign op_dal      = (op == 7'b1111111);
  assign is_kareal   = op_ozel && (f3 == 3'b000) && (f7 == 7'b0000000);
  assign is_carp     = op_ozel && (f3 == 3'b001) && (f7 == 7'b1000010);
  assign is_sifrele  = op_ozel && (f3 == 3'b100);
  assign is_tasi     = op_ozel && (f3 == 3'b101);
  assign is_bitsay   = op_ozel && (f3 == 3'b010) && (buyruk_reg[30:20] == 11'b10101010101);
  assign is_dallan   = op_dal && (f3 == 3'b111);
  assign is_atla     = op_dal && (f3 != 3'b111);
  assign is_carpma   = is_kareal || is_carp;
  assign is_gecersiz = !(is_carpma || is_sifrele || is_tasi || is_bitsay || is_dallan || is_atla);

  logic [XLEN-1:0] rs1_deger, rs2_deger;
  assign rs1_deger = (rs1 == 5'd0) ? '0 : yazmac_reg[rs1];
  assign rs2_deger = (rs2 == 5'd0) ? '0 : yazmac_reg[rs2];

  logic [XLEN-1:0] imm_i, imm_z;
  assign imm_i = {{(XLEN-12){buyruk_reg[31]}}, buyruk_reg[31:20]};
  assign imm_z = {{(XLEN-12){1'b0}}, buyruk_reg[31:20]};

  logic [31:0] ofs_b, ofs_j, pc_arti4;
  assign ofs_b    = {{21{buyruk_reg[7]}}, buyruk_reg[7], buyruk_reg[29:25], buyruk_reg[11:8], 1'b0};
  assign ofs_j    = {{10{buyruk_reg[31]}}, buyruk_reg[31], buyruk_reg[19:12], buyruk_reg[20],
                     buyruk_reg[30:21], 2'b00};
  assign pc_arti4 = pc_reg + 32'd4;

  logic [XLEN-1:0] bir_sayisi;
  always_comb begin
    bir_sayisi = '0;
    for (int k = 0; k < XLEN; k++) begin
      bir_sayisi = bir_sayisi + XLEN'(rs1_deger[k]);
    end
  end

  logic dal_alindi;
  always_comb begin
    case (buyruk_reg[31:30])
      2'b01:   dal_alindi = (rs1_deger == rs2_deger);
      2'b10:   dal_alindi = ($signed(rs1_deger) < $signed(rs2_deger));
      2'b11:   dal_alindi = ($signed(rs1_deger) >= $signed(rs2_deger));
      default: dal_alindi = 1'b0;
    endcase
  end

  logic [XLEN-1:0] basit_sonuc;
  logic            basit_yaz;
  always_comb begin
    basit_sonuc = '0;
    basit_yaz   = 1'b0;
    if (is_sifrele) begin
      basit_sonuc = rs1_deger ^ imm_i;
      basit_yaz   = 1'b1;
    end else if (is_tasi) begin
      basit_sonuc = imm_z;
      basit_yaz   = 1'b1;
    end else if (is_bitsay) begin
      basit_sonuc = buyruk_reg[31] ? bir_sayisi : (XLEN'(XLEN) - bir_sayisi);
      basit_yaz   = 1'b1;
    end else if (is_atla) begin
      basit_sonuc = XLEN'(pc_arti4);
      basit_yaz   = 1'b1;
    end
  end

  // One shift-add step: CARP_ADIM low multiplier bits against the shifted multiplicand.
  logic [XLEN-1:0] kismi, birikim_yeni;
  always_comb begin
    kismi = '0;
    for (int k = 0; k < CARP_ADIM; k++) begin
      if (carpan_reg[k]) kismi = kismi + (carpilan_reg << k);
    end
    birikim_yeni = birikim_reg + kismi;
  end

  logic carp_son;
  assign carp_son = (sayac_reg == SW'(M - 1));

  logic            yaz_en;
  logic [XLEN-1:0] yaz_veri;
  always_comb begin
    durum_next    = durum_reg;
    pc_next       = pc_reg;
    yaz_en        = 1'b0;
    yaz_veri      = basit_sonuc;
    emekli_next   = 1'b0;
    gecersiz_next = 1'b0;
    case (durum_reg)
      GETIR: if (buyruk_gecerli) durum_next = COZ;
      COZ: begin
        if (is_carpma) begin
          durum_next = CARP1;
        end else begin
          durum_next    = GETIR;
          emekli_next   = 1'b1;
          gecersiz_next = is_gecersiz;
          yaz_en        = basit_yaz;
          if (is_atla)                       pc_next = pc_reg + ofs_j;
          else if (is_dallan && dal_alindi)  pc_next = pc_reg + ofs_b;
          else                               pc_next = pc_arti4;
        end
      end
      CARP1: if (carp_son) durum_next = is_kareal ? CARP2 : YAZ;
      CARP2: if (carp_son) durum_next = YAZ;
      YAZ: begin
        durum_next  = GETIR;
        emekli_next = 1'b1;
        yaz_en      = 1'b1;
        yaz_veri    = sonuc_reg;
        pc_next     = pc_arti4;
      end
      default: durum_next = GETIR;
    endcase
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_reg    <= GETIR;
      buyruk_reg   <= '0;
      pc_reg       <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      carpilan_reg <= '0;
      carpan_reg   <= '0;
      birikim_reg  <= '0;
      urun1_reg    <= '0;
      sonuc_reg    <= '0;
      sayac_reg    <= '0;
      emekli_reg   <= 1'b0;
      gecersiz_reg <= 1'b0;
    end else begin
      durum_reg    <= durum_next;
      pc_reg       <= pc_next;
      emekli_reg   <= emekli_next;
      gecersiz_reg <= gecersiz_next;
      if (durum_reg == GETIR && buyruk_gecerli) buyruk_reg <= giris_sozcuk;
      case (durum_reg)
        COZ: begin
          op1_reg      <= rs1_deger;
          op2_reg      <= rs2_deger;
          carpilan_reg <= rs1_deger;
          carpan_reg   <= is_kareal ? rs1_deger : rs2_deger;
          birikim_reg  <= '0;
          sayac_reg    <= '0;
        end
        CARP1, CARP2: begin
          carpilan_reg <= carpilan_reg << CARP_ADIM;
          carpan_reg   <= carpan_reg >> CARP_ADIM;
          birikim_reg  <= birikim_yeni;
          sayac_reg    <= sayac_reg + SW'(1);
          if (carp_son) begin
            if (durum_reg == CARP1 && is_kareal) begin
              // First square done; restart the unit on rs2*rs2.
              urun1_reg    <= birikim_yeni;
              carpilan_reg <= op2_reg;
              carpan_reg   <= op2_reg;
              birikim_reg  <= '0;
              sayac_reg    <= '0;
            end else if (durum_reg == CARP1) begin
              sonuc_reg <= birikim_yeni - op1_reg;
            end else begin
              sonuc_reg <= urun1_reg + birikim_yeni;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) yazmac_reg[i] <= '0;
    end else if (yaz_en && rd != 5'd0) begin
      yazmac_reg[rd] <= yaz_veri;
    end
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_duzle
      assign yazmaclar[gi*XLEN +: XLEN] = yazmac_reg[gi];
    end
  endgenerate

  assign buyruk_hazir    = (durum_reg == GETIR);
  assign program_sayaci  = pc_reg;
  assign emekli          = emekli_reg;
  assign gecersiz_buyruk = gecersiz_reg;
endmodule

// File: tb/tb_islemci_cok_cevrim.sv
// Bench for islemci_cok_cevrim: a 32-bit byte-reversed core and a 64-bit native-order core
// with a 4-bit multiplier step, checked against hand-derived results via a scoreboard queue.
module tb_islemci_cok_cevrim;
  logic saat = 1'b0;
  always #5 saat = ~saat;

  logic         reset;
  logic [31:0]  buyruk_a, buyruk_b;
  logic         gecerli_a, gecerli_b;
  logic         hazir_a, hazir_b, emekli_a, emekli_b, gec_a, gec_b;
  logic [31:0]  pc_a, pc_b;
  logic [1023:0] yaz_a;
  logic [2047:0] yaz_b;

  islemci_cok_cevrim #(.XLEN(32), .CARP_ADIM(1), .BAYT_TERS(1)) dut_a (
    .saat(saat), .reset(reset), .buyruk(buyruk_a), .buyruk_gecerli(gecerli_a),
    .buyruk_hazir(hazir_a), .program_sayaci(pc_a), .yazmaclar(yaz_a),
    .emekli(emekli_a), .gecersiz_buyruk(gec_a));

  islemci_cok_cevrim #(.XLEN(64), .CARP_ADIM(4), .BAYT_TERS(0)) dut_b (
    .saat(saat), .reset(reset), .buyruk(buyruk_b), .buyruk_gecerli(gecerli_b),
    .buyruk_hazir(hazir_b), .program_sayaci(pc_b), .yazmaclar(yaz_b),
    .emekli(emekli_b), .gecersiz_buyruk(gec_b));

  int gecen = 0;
  int toplam = 0;
  int say_a = 0;
  always @(posedge saat) if (emekli_a === 1'b1) say_a <= say_a + 1;

  bit hedef = 1'b0;
  wire        o_hazir  = hedef ? hazir_b  : hazir_a;
  wire        o_emekli = hedef ? emekli_b : emekli_a;
  wire        o_gec    = hedef ? gec_b    : gec_a;
  wire [31:0] o_pc     = hedef ? pc_b     : pc_a;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [63:0] deger;
    bit          yaz;
    bit          gecersiz;
    int          gecikme;
    string       ad;
  } beklenen_t;
  beklenen_t kuyruk[$];

  logic [2047:0] anlik;
  logic [31:0]   pc_once;

  function automatic logic [2047:0] tum();
    return hedef ? yaz_b : {1024'b0, yaz_a};
  endfunction

  function automatic logic [63:0] oku(input int r);
    return hedef ? yaz_b[r*64 +: 64] : {32'b0, yaz_a[r*32 +: 32]};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, r1, f3, rd, 7'h77};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h77};
  endfunction

  function automatic logic [31:0] enc_b(input logic [1:0] mod, input logic [31:0] ofs,
                                        input logic [4:0] r2, input logic [4:0] r1);
    return {mod, ofs[9:5], r2, r1, 3'b111, ofs[4:1], ofs[10], 7'h7F};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] ofs, input logic [4:0] rd);
    return {ofs[21], ofs[11:2], ofs[12], ofs[20:13], rd, 7'h7F};
  endfunction

  task automatic gonder(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [63:0] deger, input bit yaz, input bit gecersiz,
                        input int gecikme, input string ad);
    beklenen_t b;
    b.pc = pc; b.rd = rd; b.deger = deger; b.yaz = yaz;
    b.gecersiz = gecersiz; b.gecikme = gecikme; b.ad = ad;
    kuyruk.push_back(b);
    @(negedge saat);
    toplam++;
    if (o_hazir !== 1'b1) $display("FAIL %s hazir_once: gozlenen=%b beklenen=1", ad, o_hazir);
    else gecen++;
    anlik = tum();
    pc_once = o_pc;
    if (hedef) begin
      buyruk_b = ins; gecerli_b = 1'b1;
    end else begin
      buyruk_a = {ins[7:0], ins[15:8], ins[23:16], ins[31:24]}; gecerli_a = 1'b1;
    end
    @(posedge saat);
    #1;
    gecerli_a = 1'b0; gecerli_b = 1'b0;
    buyruk_a = $urandom; buyruk_b = $urandom;
  endtask

  task automatic bekle();
    beklenen_t b;
    int k;
    bit hazir_ok, sabit_ok;
    b = kuyruk.pop_front();
    k = 0; hazir_ok = 1'b1; sabit_ok = 1'b1;
    while (k < 400) begin
      @(posedge saat);
      #1;
      k++;
      if (o_emekli === 1'b1) break;
      if (o_hazir !== 1'b0) hazir_ok = 1'b0;
      if (o_pc !== pc_once || tum() !== anlik) sabit_ok = 1'b0;
    end
    $display("islem %-12s pc=%08h gecikme=%0d gecersiz=%b", b.ad, o_pc, k, o_gec);
    toplam++;
    if (k !== b.gecikme || o_emekli !== 1'b1)
      $display("FAIL %s gecikme: gozlenen=%0d beklenen=%0d", b.ad, k, b.gecikme);
    else gecen++;
    toplam++;
    if (!hazir_ok) $display("FAIL %s hazir_mesgul: gozlenen=1 beklenen=0", b.ad);
    else gecen++;
    toplam++;
    if (!sabit_ok) $display("FAIL %s erken_degisim: gozlenen=degisti beklenen=sabit", b.ad);
    else gecen++;
    toplam++;
    if (o_pc !== b.pc) $display("FAIL %s pc: gozlenen=%h beklenen=%h", b.ad, o_pc, b.pc);
    else gecen++;
    toplam++;
    if (o_gec !== b.gecersiz)
      $display("FAIL %s gecersiz: gozlenen=%b beklenen=%b", b.ad, o_gec, b.gecersiz);
    else gecen++;
    toplam++;
    if (b.yaz) begin
      if (oku(b.rd) !== b.deger)
        $display("FAIL %s x%0d: gozlenen=%h beklenen=%h", b.ad, b.rd, oku(b.rd), b.deger);
      else gecen++;
    end else begin
      if (tum() !== anlik) $display("FAIL %s yazma_yok: yazmaclar degisti beklenen=degismez", b.ad);
      else gecen++;
    end
    toplam++;
    if (oku(0) !== 64'd0) $display("FAIL %s x0: gozlenen=%h beklenen=0", b.ad, oku(0));
    else gecen++;
    @(posedge saat);
    #1;
    toplam++;
    if (o_emekli !== 1'b0 || o_gec !== 1'b0)
      $display("FAIL %s darbe: gozlenen=%b%b beklenen=00", b.ad, o_emekli, o_gec);
    else gecen++;
  endtask

  task automatic calistir(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [63:0] deger, input bit yaz, input bit gecersiz,
                          input int gecikme, input string ad);
    gonder(ins, pc, rd, deger, yaz, gecersiz, gecikme, ad);
    bekle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge saat);
    #1;
    toplam++;
    if (pc_a !== 32'd0 || pc_b !== 32'd0)
      $display("FAIL reset_pc: gozlenen=%h/%h beklenen=0", pc_a, pc_b);
    else gecen++;
    toplam++;
    if (yaz_a !== '0 || yaz_b !== '0) $display("FAIL reset_yazmac: gozlenen=sifir_degil beklenen=0");
    else gecen++;
    toplam++;
    if (hazir_a !== 1'b1 || hazir_b !== 1'b1 || emekli_a !== 1'b0 || gec_a !== 1'b0 || emekli_b !== 1'b0)
      $display("FAIL reset_cikis: gozlenen=%b%b%b%b%b beklenen=11000",
               hazir_a, hazir_b, emekli_a, gec_a, emekli_b);
    else gecen++;
    @(negedge saat);
    reset = 1'b0;
  endtask

  task automatic test_temel();
    int s0;
    hedef = 1'b0;
    s0 = say_a;
    calistir(enc_i(12'h7FF, 5'd0, 3'd5, 5'd1), 32'd4, 5'd1, 64'h7FF,      1, 0, 1, "TASI");
    calistir(enc_i(12'h800, 5'd1, 3'd4, 5'd2), 32'd8, 5'd2, 64'hFFFFFFFF, 1, 0, 1, "SIFRELE");
    toplam++;
    if (say_a - s0 !== 2) $display("FAIL emekli_sayisi: gozlenen=%0d beklenen=2", say_a - s0);
    else gecen++;
  endtask

  task automatic test_bitsay();
    hedef = 1'b0;
    calistir(enc_i(12'h555, 5'd2, 3'd2, 5'd7), 32'd12, 5'd7, 64'd0,  1, 0, 1, "BITSAY0");
    calistir(enc_i(12'hD55, 5'd2, 3'd2, 5'd8), 32'd16, 5'd8, 64'd32, 1, 0, 1, "BITSAY1");
  endtask

  task automatic test_carpma();
    hedef = 1'b0;
    calistir(enc_i(12'd3, 5'd0, 3'd5, 5'd3), 32'd20, 5'd3, 64'd3, 1, 0, 1, "TASI3");
    calistir(enc_i(12'd4, 5'd0, 3'd5, 5'd4), 32'd24, 5'd4, 64'd4, 1, 0, 1, "TASI4");
    calistir(enc_r(7'h00, 5'd4, 5'd3, 3'd0, 5'd5), 32'd28, 5'd5, 64'd25, 1, 0, 66, "KAREAL");
    calistir(enc_r(7'h42, 5'd4, 5'd3, 3'd1, 5'd6), 32'd32, 5'd6, 64'd9,  1, 0, 34, "CARP");
    calistir(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9),  32'd36, 5'd9,  64'h3FF002,   1, 0, 66, "KAREAL2");
    calistir(enc_r(7'h42, 5'd1, 5'd2, 3'd1, 5'd10), 32'd40, 5'd10, 64'hFFFFF802, 1, 0, 34, "CARP2");
  endtask

  task automatic test_dallan();
    hedef = 1'b0;
    calistir(enc_i(12'hFFF, 5'd0, 3'd4, 5'd1), 32'd44, 5'd1, 64'hFFFFFFFF, 1, 0, 1, "X1_EKSI1");
    calistir(enc_i(12'd1, 5'd0, 3'd5, 5'd2),   32'd48, 5'd2, 64'd1,        1, 0, 1, "X2_BIR");
    calistir(enc_j(32'd16, 5'd0),                 32'h40, 5'd0, 64'd0, 0, 0, 1, "ATLA_X0");
    calistir(enc_b(2'b10, 32'd16, 5'd2, 5'd1),    32'h50, 5'd0, 64'd0, 0, 0, 1, "BLT");
    calistir(enc_b(2'b11, 32'd16, 5'd2, 5'd1),    32'h54, 5'd0, 64'd0, 0, 0, 1, "BGE");
    calistir(enc_b(2'b00, 32'd16, 5'd2, 5'd1),    32'h58, 5'd0, 64'd0, 0, 0, 1, "MOD00");
    calistir(enc_b(2'b01, -32'sd24, 5'd1, 5'd1),  32'h40, 5'd0, 64'd0, 0, 0, 1, "BEQ_EVET");
    calistir(enc_b(2'b01, -32'sd24, 5'd2, 5'd1),  32'h44, 5'd0, 64'd0, 0, 0, 1, "BEQ_HAYIR");
  endtask

  task automatic test_atla();
    hedef = 1'b0;
    calistir(enc_j(-32'sh2008, 5'd5), 32'hFFFFE03C, 5'd5, 64'h48, 1, 0, 1, "ATLA_GERI");
    calistir(enc_j(32'h2008, 5'd0),   32'h44,       5'd0, 64'd0,  0, 0, 1, "ATLA_ILERI");
  endtask

  task automatic test_bosta();
    bit ok;
    hedef = 1'b0;
    @(negedge saat);
    anlik = tum(); pc_once = o_pc; ok = 1'b1;
    gecerli_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      buyruk_a = $urandom;
      @(posedge saat);
      #1;
      if (o_hazir !== 1'b1 || o_emekli !== 1'b0 || o_pc !== pc_once || tum() !== anlik) ok = 1'b0;
    end
    $display("islem %-12s pc=%08h", "BOSTA", o_pc);
    toplam++;
    if (!ok) $display("FAIL bosta: gozlenen=durum_degisti beklenen=degismez");
    else gecen++;
  endtask

  task automatic test_genis();
    hedef = 1'b1;
    calistir(enc_i(12'h00F, 5'd0, 3'd5, 5'd1), 32'd4,  5'd1, 64'hF,  1, 0, 1, "G_TASI");
    calistir(enc_i(12'hD55, 5'd1, 3'd2, 5'd2), 32'd8,  5'd2, 64'd4,  1, 0, 1, "G_BITSAY1");
    calistir(enc_i(12'h555, 5'd1, 3'd2, 5'd3), 32'd12, 5'd3, 64'd60, 1, 0, 1, "G_BITSAY0");
    calistir(enc_i(12'h800, 5'd0, 3'd4, 5'd4), 32'd16, 5'd4, 64'hFFFFFFFFFFFFF800, 1, 0, 1, "G_SIFRELE");
    calistir(enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd5), 32'd20, 5'd5, 64'h4000E1, 1, 0, 34, "G_KAREAL");
    calistir(enc_r(7'h42, 5'd1, 5'd4, 3'd1, 5'd6), 32'd24, 5'd6, 64'hFFFFFFFFFFFF9000, 1, 0, 18, "G_CARP");
    calistir(enc_j(32'h100, 5'd7), 32'h118, 5'd7, 64'd28, 1, 0, 1, "G_ATLA");
    hedef = 1'b0;
  endtask

  task automatic test_reset_ortasi();
    logic [31:0] ins;
    bit sessiz;
    hedef = 1'b0;
    ins = enc_r(7'h00, 5'd4, 5'd3, 3'd0, 5'd5);
    @(negedge saat);
    buyruk_a = {ins[7:0], ins[15:8], ins[23:16], ins[31:24]};
    gecerli_a = 1'b1;
    @(posedge saat);
    #1;
    gecerli_a = 1'b0;
    @(posedge saat);
    repeat (9) @(posedge saat);
    @(negedge saat);
    ins = enc_i(12'd1, 5'd0, 3'd5, 5'd1);
    buyruk_a = {ins[7:0], ins[15:8], ins[23:16], ins[31:24]};
    gecerli_a = 1'b1;
    reset = 1'b1;
    @(posedge saat);
    #1;
    $display("islem %-12s pc=%08h hazir=%b", "RESET_CARP1", pc_a, hazir_a);
    toplam++;
    if (pc_a !== 32'd0 || yaz_a !== '0 || yaz_b !== '0 || pc_b !== 32'd0)
      $display("FAIL reset_ortasi_durum: gozlenen=pc %h beklenen=pc 0 ve yazmaclar 0", pc_a);
    else gecen++;
    toplam++;
    if (hazir_a !== 1'b1 || emekli_a !== 1'b0 || gec_a !== 1'b0)
      $display("FAIL reset_ortasi_cikis: gozlenen=%b%b%b beklenen=100", hazir_a, emekli_a, gec_a);
    else gecen++;
    @(negedge saat);
    reset = 1'b0;
    gecerli_a = 1'b0;
    sessiz = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge saat);
      #1;
      if (emekli_a !== 1'b0 || pc_a !== 32'd0) sessiz = 1'b0;
    end
    toplam++;
    if (!sessiz) $display("FAIL reset_sonrasi_emekli: gozlenen=emekli beklenen=sessiz");
    else gecen++;
  endtask

  task automatic test_gecersiz();
    hedef = 1'b0;
    calistir(enc_i(12'h123, 5'd0, 3'd5, 5'd5), 32'd4, 5'd5, 64'h123, 1, 0, 1, "X5_HAZIRLA");
    calistir(32'h00000033,                         32'd8,  5'd5, 64'd0, 0, 1, 1, "GEC_33");
    calistir(enc_r(7'h01, 5'd4, 5'd3, 3'd0, 5'd5), 32'd12, 5'd5, 64'd0, 0, 1, 1, "GEC_F7");
    calistir(enc_i(12'd0, 5'd1, 3'd3, 5'd5),       32'd16, 5'd5, 64'd0, 0, 1, 1, "GEC_F3");
    calistir(enc_i(12'h554, 5'd5, 3'd2, 5'd5),     32'd20, 5'd5, 64'd0, 0, 1, 1, "GEC_BITSAY");
  endtask

  initial begin
    reset = 1'b1;
    buyruk_a = '0; buyruk_b = '0;
    gecerli_a = 1'b0; gecerli_b = 1'b0;
    test_reset();
    test_temel();
    test_bitsay();
    test_carpma();
    test_dallan();
    test_atla();
    test_bosta();
    test_genis();
    test_reset_ortasi();
    test_gecersiz();
    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end
endmodule

// File: doc/islemci_cok_cevrim.md
# islemci_cok_cevrim

Multi-cycle, parametrised successor of the single-cycle custom-ISA core. It executes the same seven custom instructions (KAREAL.TOPLA, CARP.CIKAR, SIFRELE, TASI, BITSAY, SEC.DALLAN, IKIKAT.ATLA) at a configurable data width. Multiplication uses an iterative shift-add unit instead of a combinational multiplier. Instruction fetch uses a valid/ready handshake, branches are PC-relative, and undefined encodings are flagged.

## Interface
- XLEN, 32: register/data width; 32 or 64.
- CARP_ADIM, 1: multiplier bits consumed per cycle; must divide XLEN; M = XLEN/CARP_ADIM.
- BAYT_TERS, 1: 1 = `buyruk` arrives byte-reversed (instruction byte 0 in [31:24]); 0 = native order.
- saat  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- buyruk  in  32  instruction word at `program_sayaci`.
- buyruk_gecerli  in  1  `buyruk` valid this cycle.
- buyruk_hazir  out  1  core accepts an instruction this cycle; reset 1.
- program_sayaci  out  32  address of the next instruction; reset 0.
- yazmaclar  out  32*XLEN  register file, flattened; xi at [i*XLEN +: XLEN]; reset all 0.
- emekli  out  1  one-cycle pulse when an instruction retires; reset 0.
- gecersiz_buyruk  out  1  one-cycle pulse, coincident with `emekli`, for an undefined encoding; reset 0.

## Operation
- Decode fields from the (optionally byte-swapped) word I:
  - op = I[6:0], rd = I[11:7], f3 = I[14:12], rs1 = I[19:15], rs2 = I[24:20], f7 = I[31:25].
  - immI = sext(I[31:20]) to XLEN.
- KAREAL.TOPLA: op 1110111, f3 000, f7 0000000. rd = rs1*rs1 + rs2*rs2, mod 2^XLEN.
- CARP.CIKAR: op 1110111, f3 001, f7 1000010. rd = rs1*rs2 − rs1, mod 2^XLEN.
- SIFRELE: op 1110111, f3 100. rd = rs1 ^ immI.
- TASI: op 1110111, f3 101. rd = zext(I[31:20]).
- BITSAY: op 1110111, f3 010, I[30:20] = 10101010101.
  - I[31]=1: rd = popcount(rs1).
  - I[31]=0: rd = XLEN − popcount(rs1).
- SEC.DALLAN: op 1111111, f3 111. Offset B = sext({I[7], I[29:25], I[11:8], 0}).
  - Mode I[31:30]: 00 no branch; 01 branch if rs1 == rs2; 10 branch if signed rs1 < rs2; 11 branch if signed rs1 ≥ rs2.
  - Taken: PC = PC + B. Otherwise PC = PC + 4.
- IKIKAT.ATLA: op 1111111, f3 ≠ 111. rd = PC + 4, zero-extended to XLEN. PC = PC + sext({I[31], I[19:12], I[20], I[30:21], 00}).
- All other encodings:
  - No register write, PC = PC + 4.
  - `gecersiz_buyruk` pulses.
- All other instructions: PC = PC + 4. PC arithmetic is mod 2^32.
- x0 always reads 0. Writes to x0 are discarded.
- Operands are read in COZ. Products use operands latched in COZ.

## Timing
- FSM states:
  - GETIR: `buyruk_hazir` = 1.
  - COZ
  - CARP1
  - CARP2
  - YAZ
- GETIR: on an edge with `buyruk_gecerli` = 1, latch `buyruk` and go to COZ. With `buyruk_gecerli` = 0, stay in GETIR. `buyruk` is ignored in every other state.
- COZ:
  - Non-multiply instructions: perform the write and PC update on this edge, pulse `emekli`, go to GETIR.
  - Multiply instructions: go to CARP1.
- CARP1: M cycles produce the first product (rs1*rs1 or rs1*rs2). Next state is CARP2 for KAREAL.TOPLA, YAZ for CARP.CIKAR.
- CARP2: M cycles produce rs2*rs2.
- YAZ: write rd, PC += 4, pulse `emekli`, go to GETIR.
- Latency from the accept edge to the retire edge:
  - Simple instructions: 1 cycle, for a throughput of 2 cycles per instruction.
  - CARP.CIKAR: M+2 cycles.
  - KAREAL.TOPLA: 2M+2 cycles.
- `program_sayaci` and `yazmaclar` change only on retire edges.
- Reset in any state, including mid-multiply: the next edge clears all registers, PC, partial products and pulses, and the FSM goes to GETIR. Nothing is retired.
- Simultaneous `reset` and `buyruk_gecerli`: reset wins and the instruction is not accepted.

## Test plan
- XLEN=32, BAYT_TERS=1. Run TASI x1,0x7FF, then SIFRELE x2,x1,0x800 → x1 = 0x000007FF, x2 = 0xFFFFFFFF, PC = 8, `emekli` pulsed twice.
- x3=3, x4=4. Run KAREAL.TOPLA x5,x3,x4 → `emekli` exactly 66 cycles after accept, x5 = 25, `buyruk_hazir` low throughout. Then run CARP.CIKAR x6,x3,x4 → x6 = 9 after 34 cycles.
- x2 = 0xFFFFFFFF. BITSAY with I[31]=0 → 0. BITSAY with I[31]=1 → 32. With XLEN=64 and rs1 = 0xF → 4 and 60.
- x1 = −1, x2 = 1, PC = 0x40:
  - BLT mode, offset +16 → PC = 0x50.
  - BGE mode → PC = 0x44.
  - Mode 00 → PC = 0x44 with no write.
- IKIKAT.ATLA from PC = 0x10:
  - rd = x5, offset −8 → x5 = 0x14, PC = 0x08.
  - rd = x0 → x0 stays 0.
  - Hold `buyruk_gecerli` low for 5 cycles → no state change.
- Assert reset in cycle 10 of CARP1 → registers and PC are 0 next cycle, `buyruk_hazir` = 1. Opcode 0x33 → `gecersiz_buyruk` and `emekli` pulse, PC += 4, no write.
